fb_scanout_arbiter: RTL
=======================

FB_SCANOUT_ARBITER -- requirements
Module: fb_scanout_arbiter

Interface
REQ-001 SHALL have parameters: FB_W 160, framebuffer width in cells; FB_H 120, height in cells; CW 8, colour width in bits.
REQ-002 SHALL have ports: i_clk in 1, the single clock; i_rst in 1, reset (asynchronous, active-high).
REQ-003 SHALL have ports: i_pix_stb in 1, pixel strobe; i_active in 1, timing generator in active area; i_x in 10, pixel x; i_y in 9, pixel y; i_animate in 1, one-tick end-of-frame pulse.
REQ-004 SHALL have ports: i_req in 2, write request per client; i_addr0/i_addr1 in 15, cell address; i_data0/i_data1 in CW, colour; o_gnt out 2, one-hot accept pulse.
REQ-005 SHALL have ports: o_mem_addr out 16, RAM address (bit 15 is the bank); o_mem_we out 1; o_mem_wdata out CW; i_mem_rdata in CW, registered-read RAM data with 1-cycle latency.
REQ-006 SHALL have ports: o_pix out CW, display colour; o_pix_valid out 1; i_swap in 1, swap request; o_swapped out 1, swap pulse.

Function
REQ-007 SHALL treat a cycle with i_pix_stb=1 and i_active=1 as a DISPLAY slot: o_mem_we=0, o_mem_addr = front bank : (i_y[8:2]*FB_W + i_x[9:2]).
REQ-008 SHALL compute the scan address without a multiplier: (y<<7)+(y<<5)+x, 15 bits, maximum 19199.
REQ-009 SHALL capture i_mem_rdata into o_pix one cycle after a DISPLAY slot and pulse o_pix_valid for that cycle; o_pix holds between slots.
REQ-010 SHALL treat every other cycle as a WRITE slot and grant one requesting client via round-robin; the last-granted client has the lower priority next slot.
REQ-011 SHALL, on a grant, assert o_gnt[k] for exactly that cycle and drive o_mem_we=1, o_mem_addr = back bank : i_addrk, o_mem_wdata=i_datak.
REQ-012 SHALL, for i_addrk >= FB_W*FB_H, still pulse o_gnt[k] but hold o_mem_we=0 (request dropped).
REQ-013 SHALL keep a client's request, address and data stable until its o_gnt; the block never grants a deasserted request.
REQ-014 SHALL give DISPLAY strict priority: no grant occurs in a DISPLAY slot regardless of pending requests.
REQ-015 SHALL implement the FSM IDLE -> DISP or WR0/WR1 each cycle (combinational select, registered last-grant pointer); WR is chosen only with a pending request, otherwise IDLE with o_mem_we=0.
REQ-016 SHALL latch i_swap as a sticky pending flag; on i_animate with the flag set, toggle the front-bank bit, clear the flag and pulse o_swapped for one cycle.
REQ-017 SHALL treat i_swap and i_animate in the same cycle as a swap taking effect at that i_animate.

Reset
REQ-018 SHALL, while i_rst=1, force o_gnt=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_pix=0, o_pix_valid=0, o_swapped=0, front bank=0, pointer=client 0, swap flag=0.
REQ-019 SHALL discard an in-flight read when reset is asserted mid-operation; the first slot after release is arbitrated normally.

Configuration
REQ-020 SHALL compile double buffering in with FB_DOUBLE_BUFFER_EN: front/back banks and swap as in REQ-016.
REQ-021 SHALL, without FB_DOUBLE_BUFFER_EN, hold o_mem_addr[15]=0 for both slot types, hold o_swapped=0 and ignore i_swap.

Structure
REQ-022 SHALL place FB_W, FB_H, CW, the cell-address width and the slot enum (IDLE, DISP, WR0, WR1) in package fb_pkg.
REQ-023 SHALL implement round-robin selection in sub-module rr_arb2 (2 requests, last-grant in, one-hot grant out).

Verification
REQ-024 Scan (x=5,y=9), stb=1, active=1 -> o_mem_addr=0x0141 (321), o_mem_we=0; o_pix_valid 1 cycle later with rdata.
REQ-025 i_req=2'b11 held, active=0 for 4 cycles -> o_gnt 01,10,01,10; writes at the respective addresses.
REQ-026 i_req0 with stb=1, active=1 -> o_gnt=0 that cycle; grant on the first non-display cycle.
REQ-027 i_addr0=19200 -> o_gnt[0]=1, o_mem_we=0.
REQ-028 With FB_DOUBLE_BUFFER_EN: i_swap pulse, then i_animate -> o_swapped=1 one cycle; display bit15=1, write bit15=0.
REQ-029 Assert i_rst during a grant -> outputs return to the REQ-018 values immediately; next grant goes to client 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan-out arbiter.
//   FB_W, FB_H : framebuffer size in cells
//   CW         : colour width in bits
//   CELL_AW    : cell-address width
//   slot_e     : per-cycle memory slot (IDLE, DISP, WR0, WR1)
//   scan_addr  : multiplier-free y*160 + x cell address
package fb_pkg;

  localparam int unsigned FB_W    = 160;
  localparam int unsigned FB_H    = 120;
  localparam int unsigned CW      = 8;
  localparam int unsigned CELL_AW = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    WR0  = 2'd2,
    WR1  = 2'd3
  } slot_e;

  // y*160 + x as (y<<7) + (y<<5) + x; tops out at 119*160+159 = 19199.
  function automatic logic [CELL_AW-1:0] scan_addr(input logic [6:0] cy, input logic [7:0] cx);
    logic [CELL_AW-1:0] y_ext;
    logic [CELL_AW-1:0] x_ext;
    y_ext = {8'd0, cy};
    x_ext = {7'd0, cx};
    return (y_ext << 7) + (y_ext << 5) + x_ext;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin selector (combinational).
//   req_i  : request per client
//   last_i : index of the client granted most recently (it loses a tie)
//   gnt_o  : one-hot grant, zero when nothing is requested
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Framebuffer RAM port arbiter: display scan-out has strict priority, remaining
// cycles are shared round-robin between two write clients.
// Optional double buffering: define FB_DOUBLE_BUFFER_EN.
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_pix_stb, i_active, i_x/i_y : timing generator; stb & active = display slot
//   i_animate                    : end-of-frame pulse, point where a swap lands
//   i_req, i_addrN, i_dataN, o_gnt : write clients, o_gnt pulses on accept
//   o_mem_*, i_mem_rdata         : RAM port, bit 15 of address selects bank,
//                                  read data arrives one cycle after the address
//   o_pix, o_pix_valid           : display colour, valid one cycle after a display slot
//   i_swap, o_swapped            : swap request, pulse when banks have swapped
module fb_scanout_arbiter #(
  parameter int unsigned FB_W = fb_pkg::FB_W,
  parameter int unsigned FB_H = fb_pkg::FB_H,
  parameter int unsigned CW   = fb_pkg::CW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_stb,
  input  logic          i_active,
  input  logic [9:0]    i_x,
  input  logic [8:0]    i_y,
  input  logic          i_animate,
  input  logic [1:0]    i_req,
  input  logic [14:0]   i_addr0,
  input  logic [14:0]   i_addr1,
  input  logic [CW-1:0] i_data0,
  input  logic [CW-1:0] i_data1,
  output logic [1:0]    o_gnt,
  output logic [15:0]   o_mem_addr,
  output logic          o_mem_we,
  output logic [CW-1:0] o_mem_wdata,
  input  logic [CW-1:0] i_mem_rdata,
  output logic [CW-1:0] o_pix,
  output logic          o_pix_valid,
  input  logic          i_swap,
  output logic          o_swapped
);

  import fb_pkg::*;

  localparam logic [CELL_AW-1:0] NumCells = CELL_AW'(FB_W * FB_H);

  slot_e         slot_d, slot_q;
  logic          ptr_d, ptr_q;      // client holding priority on a tie
  logic [CW-1:0] pix_d, pix_q;
  logic          front_d, front_q;
  logic          swap_pend_d, swap_pend_q;
  logic          swapped_d, swapped_q;
  logic [1:0]    rr_gnt;
  logic          back;

  logic unused_in;
`ifdef FB_DOUBLE_BUFFER_EN
  assign unused_in = ^{i_x[1:0], i_y[1:0]};
`else
  assign unused_in = ^{i_x[1:0], i_y[1:0], i_swap, i_animate};
`endif

  rr_arb2 u_rr_arb2 (
    .req_i  (i_req),
    .last_i (~ptr_q),
    .gnt_o  (rr_gnt)
  );

  // Slot select and RAM port drive; all forced idle while reset is held.
  always_comb begin
`ifdef FB_DOUBLE_BUFFER_EN
    back = ~front_q;
`else
    back = 1'b0;
`endif
    slot_d      = IDLE;
    ptr_d       = ptr_q;
    o_gnt       = 2'b00;
    o_mem_we    = 1'b0;
    o_mem_addr  = 16'd0;
    o_mem_wdata = '0;
    if (i_pix_stb && i_active) begin
      slot_d     = DISP;
      o_mem_addr = {front_q, scan_addr(i_y[8:2], i_x[9:2])};
    end else if (rr_gnt[0]) begin
      slot_d      = WR0;
      ptr_d       = 1'b1;
      o_gnt       = 2'b01;
      o_mem_addr  = {back, i_addr0};
      o_mem_wdata = i_data0;
      o_mem_we    = (i_addr0 < NumCells);
    end else if (rr_gnt[1]) begin
      slot_d      = WR1;
      ptr_d       = 1'b0;
      o_gnt       = 2'b10;
      o_mem_addr  = {back, i_addr1};
      o_mem_wdata = i_data1;
      o_mem_we    = (i_addr1 < NumCells);
    end
    if (i_rst) begin
      slot_d      = IDLE;
      ptr_d       = 1'b0;
      o_gnt       = 2'b00;
      o_mem_we    = 1'b0;
      o_mem_addr  = 16'd0;
      o_mem_wdata = '0;
    end
  end

  // Read data for the previous display slot is on i_mem_rdata now.
  always_comb begin
    o_pix_valid = (slot_q == DISP);
    o_pix       = o_pix_valid ? i_mem_rdata : pix_q;
    pix_d       = o_pix;
    o_swapped   = swapped_q;
  end

  always_comb begin
    swap_pend_d = swap_pend_q;
    front_d     = front_q;
    swapped_d   = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
    // A swap raised in the same cycle as i_animate lands on that i_animate.
    swap_pend_d = swap_pend_q | i_swap;
    if (i_animate && swap_pend_d) begin
      front_d     = ~front_q;
      swap_pend_d = 1'b0;
      swapped_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q      <= IDLE;
      ptr_q       <= 1'b0;
      pix_q       <= '0;
      front_q     <= 1'b0;
      swap_pend_q <= 1'b0;
      swapped_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      ptr_q       <= ptr_d;
      pix_q       <= pix_d;
      front_q     <= front_d;
      swap_pend_q <= swap_pend_d;
      swapped_q   <= swapped_d;
    end
  end

endmodule
